// File: rtl/ccd_cfg_sequencer.sv
// UART command decoder and frame-aligned configuration scheduler for the CCD201 timing path.
// Commands are validated and staged here; all staged fields commit together at a frame boundary.
module ccd_cfg_sequencer #(
  parameter int          INTEG_MIN    = 760,
  parameter logic [23:0] SYNC_TIMEOUT = 24'd8_000_000
) (
  input  logic         CLK_SYS,
  input  logic         RST_N,
  input  logic         uart_ready,
  input  logic [255:0] UART_IN,
  input  logic         frame_sync,
  output logic [15:0]  rphi1_pat,
  output logic [15:0]  rphi2_pat,
  output logic [15:0]  rphi3_pat,
  output logic [15:0]  phir_pat,
  output logic [15:0]  rphi2hv_pat,
  output logic [15:0]  pix_pat,
  output logic [15:0]  integ_t,
  output logic         os_select,
  output logic         os_rst,
  output logic         cfg_update,
  output logic         pending,
  output logic         cmd_ack,
  output logic         cmd_err,
  output logic [1:0]   err_code,
  output logic         sync_lost
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_COMMIT} state_t;

  localparam logic [15:0] INTEG_MIN_W = 16'(INTEG_MIN);
  // Field order: rphi1, rphi2, rphi3, phir, rphi2hv, pix, integ_t (index 0..6); os_select is index 7.
  localparam logic [6:0][15:0] RST_VAL = {16'd1059, 16'h00F0, 16'hF003, 16'h2000,
                                          16'h0F80, 16'hF800, 16'h80FF};

  state_t            r_state, w_nxt;
  logic [6:0][15:0]  r_stg, r_act;
  logic              r_stg_os, r_act_os;
  logic [7:0]        r_mask, w_mask_nxt;
  logic [23:0]       r_cnt;
  logic              r_fs1, r_fs2, r_fs3;
  logic              r_pending, r_ack, r_nak, r_cfg_update, r_os_rst, r_sync_lost;
  logic [1:0]        r_err_code;

  logic [15:0] w_op, w_val;
  logic [2:0]  w_idx;
  logic [1:0]  w_err;
  logic        w_is_wr, w_force, w_clr;
  logic        w_acc_wr, w_acc_force, w_acc_clr;
  logic        w_sync_edge, w_timeout, w_set_lost;

  assign w_op  = UART_IN[31:16];
  assign w_val = UART_IN[15:0];

  always_comb begin
    w_idx   = 3'd0;
    w_err   = 2'd0;
    w_is_wr = 1'b0;
    w_force = 1'b0;
    w_clr   = 1'b0;
    if (|UART_IN[255:32]) begin
      w_err = 2'd2;
    end else begin
      case (w_op)
        16'hB1A1: begin w_idx = 3'd0; w_is_wr = 1'b1; end
        16'hB1A2: begin w_idx = 3'd1; w_is_wr = 1'b1; end
        16'hB1A3: begin w_idx = 3'd2; w_is_wr = 1'b1; end
        16'hB1A4: begin w_idx = 3'd3; w_is_wr = 1'b1; end
        16'hB1A5: begin w_idx = 3'd4; w_is_wr = 1'b1; end
        16'hB1A6: begin
          w_idx = 3'd5;
          // A constant pixel pattern would stop the pixel clock entirely.
          if (w_val == 16'h0000 || w_val == 16'hFFFF) w_err = 2'd3;
          else w_is_wr = 1'b1;
        end
        16'hA1A1: begin
          w_idx = 3'd6;
          if (w_val < INTEG_MIN_W) w_err = 2'd3;
          else w_is_wr = 1'b1;
        end
        16'hA0A0: begin
          w_idx = 3'd7;
          if (w_val > 16'd1) w_err = 2'd3;
          else w_is_wr = 1'b1;
        end
        16'hC0C0: w_force = 1'b1;
        16'hC0C1: w_clr   = 1'b1;
        default:  w_err   = 2'd1;
      endcase
    end
  end

  assign w_acc_wr    = uart_ready & w_is_wr;
  assign w_acc_force = uart_ready & w_force;
  assign w_acc_clr   = uart_ready & w_clr;

  assign w_sync_edge = r_fs2 & ~r_fs3;
  assign w_timeout   = (r_cnt == SYNC_TIMEOUT - 24'd1);

  always_comb begin
    w_nxt      = r_state;
    w_set_lost = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc_force)   w_nxt = S_COMMIT;
        else if (w_acc_wr) w_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (w_sync_edge || w_acc_force) begin
          w_nxt = S_COMMIT;
        end else if (w_timeout) begin
          w_nxt      = S_COMMIT;
          w_set_lost = 1'b1;
        end
      end
      S_COMMIT: w_nxt = w_acc_wr ? S_ARMED : S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  // A write landing in the commit cycle survives the mask clear.
  always_comb begin
    w_mask_nxt = (r_state == S_COMMIT) ? 8'd0 : r_mask;
    if (w_acc_wr) w_mask_nxt[w_idx] = 1'b1;
  end

  always_ff @(posedge CLK_SYS or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_stg        <= RST_VAL;
      r_act        <= RST_VAL;
      r_stg_os     <= 1'b0;
      r_act_os     <= 1'b0;
      r_mask       <= 8'd0;
      r_cnt        <= 24'd0;
      r_fs1        <= 1'b0;
      r_fs2        <= 1'b0;
      r_fs3        <= 1'b0;
      r_pending    <= 1'b0;
      r_ack        <= 1'b0;
      r_nak        <= 1'b0;
      r_err_code   <= 2'd0;
      r_cfg_update <= 1'b0;
      r_os_rst     <= 1'b0;
      r_sync_lost  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_fs1   <= frame_sync;
      r_fs2   <= r_fs1;
      r_fs3   <= r_fs2;

      if (r_state != S_ARMED)         r_cnt <= 24'd0;
      else if (r_cnt != 24'hFF_FFFF)  r_cnt <= r_cnt + 24'd1;

      if (w_acc_wr) begin
        if (w_idx == 3'd7) r_stg_os <= w_val[0];
        else               r_stg[w_idx] <= w_val;
      end
      r_mask    <= w_mask_nxt;
      r_pending <= (w_mask_nxt != 8'd0);

      r_cfg_update <= (r_state == S_COMMIT);
      r_os_rst     <= (r_state == S_COMMIT) && (r_stg_os != r_act_os);
      if (r_state == S_COMMIT) begin
        r_act    <= r_stg;
        r_act_os <= r_stg_os;
      end

      r_ack <= uart_ready && (w_err == 2'd0);
      r_nak <= uart_ready && (w_err != 2'd0);
      if (uart_ready) r_err_code <= w_err;

      if (w_set_lost)     r_sync_lost <= 1'b1;
      else if (w_acc_clr) r_sync_lost <= 1'b0;
    end
  end

  assign rphi1_pat   = r_act[0];
  assign rphi2_pat   = r_act[1];
  assign rphi3_pat   = r_act[2];
  assign phir_pat    = r_act[3];
  assign rphi2hv_pat = r_act[4];
  assign pix_pat     = r_act[5];
  assign integ_t     = r_act[6];
  assign os_select   = r_act_os;
  assign os_rst      = r_os_rst;
  assign cfg_update  = r_cfg_update;
  assign pending     = r_pending;
  assign cmd_ack     = r_ack;
  assign cmd_err     = r_nak;
  assign err_code    = r_err_code;
  assign sync_lost   = r_sync_lost;

endmodule

// File: tb/tb_ccd_cfg_sequencer.sv
// Directed bench for ccd_cfg_sequencer: decode, staging, frame-aligned commit, timeout and reset.
module tb_ccd_cfg_sequencer;

  logic         CLK_SYS = 1'b0;
  logic         RST_N = 1'b0;
  logic         uart_ready = 1'b0;
  logic [255:0] UART_IN = '0;
  logic         frame_sync = 1'b0;
  logic [15:0]  rphi1_pat, rphi2_pat, rphi3_pat, phir_pat, rphi2hv_pat, pix_pat, integ_t;
  logic         os_select, os_rst, cfg_update, pending, cmd_ack, cmd_err, sync_lost;
  logic [1:0]   err_code;

  int n_vec = 0;
  int n_err = 0;

  ccd_cfg_sequencer #(.INTEG_MIN(760), .SYNC_TIMEOUT(24'd100)) dut (
    .CLK_SYS(CLK_SYS), .RST_N(RST_N), .uart_ready(uart_ready), .UART_IN(UART_IN),
    .frame_sync(frame_sync), .rphi1_pat(rphi1_pat), .rphi2_pat(rphi2_pat),
    .rphi3_pat(rphi3_pat), .phir_pat(phir_pat), .rphi2hv_pat(rphi2hv_pat),
    .pix_pat(pix_pat), .integ_t(integ_t), .os_select(os_select), .os_rst(os_rst),
    .cfg_update(cfg_update), .pending(pending), .cmd_ack(cmd_ack), .cmd_err(cmd_err),
    .err_code(err_code), .sync_lost(sync_lost)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  // One-cycle command strobe; returns just after the capturing edge so registered responses are visible.
  task automatic send(input logic [15:0] op, input logic [15:0] val, input logic [223:0] hi);
    @(negedge CLK_SYS);
    uart_ready = 1'b1;
    UART_IN    = {hi, op, val};
    @(posedge CLK_SYS);
    #1;
    uart_ready = 1'b0;
    UART_IN    = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK_SYS);
    #1;
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    idle(3);
    RST_N = 1'b1;
    idle(2);
    n_vec++;
    if (rphi1_pat !== 16'h80FF || rphi2_pat !== 16'hF800 || rphi3_pat !== 16'h0F80 ||
        phir_pat !== 16'h2000 || rphi2hv_pat !== 16'hF003) begin
      n_err++;
      $display("FAIL reset_pats got %h %h %h %h %h want 80ff f800 0f80 2000 f003",
               rphi1_pat, rphi2_pat, rphi3_pat, phir_pat, rphi2hv_pat);
    end
    n_vec++;
    if (pix_pat !== 16'h00F0 || integ_t !== 16'd1059 || os_select !== 1'b0) begin
      n_err++;
      $display("FAIL reset_misc got pix=%h integ=%0d os=%b want 00f0 1059 0", pix_pat, integ_t, os_select);
    end
    n_vec++;
    if ({pending, cfg_update, cmd_ack, cmd_err, err_code, sync_lost, os_rst} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_flags got pend=%b upd=%b ack=%b err=%b code=%0d lost=%b osrst=%b want all 0",
               pending, cfg_update, cmd_ack, cmd_err, err_code, sync_lost, os_rst);
    end
  endtask

  task automatic test_stage_commit;
    int upd_cnt;
    send(16'hB1A2, 16'hF000, '0);
    n_vec++;
    if (cmd_ack !== 1'b1 || pending !== 1'b1 || rphi2_pat !== 16'hF800) begin
      n_err++;
      $display("FAIL stage_ack got ack=%b pend=%b rphi2=%h want 1 1 f800", cmd_ack, pending, rphi2_pat);
    end
    @(negedge CLK_SYS);
    frame_sync = 1'b1;
    idle(3);
    n_vec++;
    if (rphi2_pat !== 16'hF800 || cfg_update !== 1'b0) begin
      n_err++;
      $display("FAIL sync_early got rphi2=%h upd=%b want f800 0", rphi2_pat, cfg_update);
    end
    idle(1);
    n_vec++;
    if (rphi2_pat !== 16'hF000 || cfg_update !== 1'b1 || pending !== 1'b0) begin
      n_err++;
      $display("FAIL sync_commit got rphi2=%h upd=%b pend=%b want f000 1 0", rphi2_pat, cfg_update, pending);
    end
    upd_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      if (cfg_update) upd_cnt++;
    end
    n_vec++;
    if (upd_cnt != 0) begin
      n_err++;
      $display("FAIL sync_held got extra_updates=%0d want 0", upd_cnt);
    end
    frame_sync = 1'b0;
    idle(4);
  endtask

  task automatic test_errors;
    send(16'hB1A7, 16'h1234, '0);
    n_vec++;
    if (cmd_err !== 1'b1 || cmd_ack !== 1'b0 || err_code !== 2'd1) begin
      n_err++;
      $display("FAIL err_opcode got err=%b ack=%b code=%0d want 1 0 1", cmd_err, cmd_ack, err_code);
    end
    send(16'hB1A1, 16'h1234, 224'h100);
    n_vec++;
    if (cmd_err !== 1'b1 || err_code !== 2'd2) begin
      n_err++;
      $display("FAIL err_upper got err=%b code=%0d want 1 2", cmd_err, err_code);
    end
    send(16'hB1A6, 16'hFFFF, '0);
    n_vec++;
    if (cmd_err !== 1'b1 || err_code !== 2'd3) begin
      n_err++;
      $display("FAIL err_pix got err=%b code=%0d want 1 3", cmd_err, err_code);
    end
    send(16'hA1A1, 16'd700, '0);
    n_vec++;
    if (cmd_err !== 1'b1 || err_code !== 2'd3 || pending !== 1'b0) begin
      n_err++;
      $display("FAIL err_integ got err=%b code=%0d pend=%b want 1 3 0", cmd_err, err_code, pending);
    end
    idle(2);
    n_vec++;
    if (cmd_err !== 1'b0 || err_code !== 2'd3) begin
      n_err++;
      $display("FAIL err_hold got err=%b code=%0d want 0 3", cmd_err, err_code);
    end
    // Forced commit from IDLE: one update pulse, nothing changes.
    send(16'hC0C0, 16'h0000, '0);
    n_vec++;
    if (cmd_ack !== 1'b1 || err_code !== 2'd0) begin
      n_err++;
      $display("FAIL force_ack got ack=%b code=%0d want 1 0", cmd_ack, err_code);
    end
    idle(1);
    n_vec++;
    if (cfg_update !== 1'b1 || rphi1_pat !== 16'h80FF || pix_pat !== 16'h00F0 ||
        integ_t !== 16'd1059 || rphi2_pat !== 16'hF000) begin
      n_err++;
      $display("FAIL force_idle got upd=%b rphi1=%h pix=%h integ=%0d rphi2=%h want 1 80ff 00f0 1059 f000",
               cfg_update, rphi1_pat, pix_pat, integ_t, rphi2_pat);
    end
    idle(1);
    n_vec++;
    if (cfg_update !== 1'b0) begin
      n_err++;
      $display("FAIL force_pulse got upd=%b want 0", cfg_update);
    end
  endtask

  task automatic test_last_wins;
    send(16'hB1A3, 16'h1111, '0);
    send(16'hB1A3, 16'h2222, '0);
    send(16'hC0C0, 16'h0000, '0);
    idle(1);
    n_vec++;
    if (rphi3_pat !== 16'h2222 || cfg_update !== 1'b1 || pending !== 1'b0) begin
      n_err++;
      $display("FAIL last_wins got rphi3=%h upd=%b pend=%b want 2222 1 0", rphi3_pat, cfg_update, pending);
    end
    idle(2);
  endtask

  task automatic test_timeout;
    int rst_cnt;
    send(16'hA0A0, 16'h0001, '0);
    rst_cnt = 0;
    for (int i = 1; i <= 105; i++) begin
      idle(1);
      if (os_rst) rst_cnt++;
      if (i == 100) begin
        n_vec++;
        if (os_select !== 1'b0 || sync_lost !== 1'b1) begin
          n_err++;
          $display("FAIL timeout_pre got os=%b lost=%b want 0 1", os_select, sync_lost);
        end
      end
      if (i == 101) begin
        n_vec++;
        if (os_select !== 1'b1 || os_rst !== 1'b1 || cfg_update !== 1'b1) begin
          n_err++;
          $display("FAIL timeout_commit got os=%b osrst=%b upd=%b want 1 1 1", os_select, os_rst, cfg_update);
        end
      end
    end
    n_vec++;
    if (rst_cnt != 1 || sync_lost !== 1'b1 || pending !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_after got osrst_pulses=%0d lost=%b pend=%b want 1 1 0", rst_cnt, sync_lost, pending);
    end
    send(16'hC0C1, 16'h0000, '0);
    n_vec++;
    if (sync_lost !== 1'b0 || cmd_ack !== 1'b1) begin
      n_err++;
      $display("FAIL clr_lost got lost=%b ack=%b want 0 1", sync_lost, cmd_ack);
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    send(16'hB1A1, 16'h00FF, '0);
    @(negedge CLK_SYS);
    frame_sync = 1'b1;
    repeat (3) @(posedge CLK_SYS);
    // This write is captured on the commit edge itself.
    send(16'hB1A1, 16'h0F0F, '0);
    n_vec++;
    if (rphi1_pat !== 16'h00FF || cfg_update !== 1'b1 || pending !== 1'b1 || cmd_ack !== 1'b1) begin
      n_err++;
      $display("FAIL collide got rphi1=%h upd=%b pend=%b ack=%b want 00ff 1 1 1",
               rphi1_pat, cfg_update, pending, cmd_ack);
    end
    frame_sync = 1'b0;
    idle(4);
    n_vec++;
    if (rphi1_pat !== 16'h00FF || pending !== 1'b1) begin
      n_err++;
      $display("FAIL collide_wait got rphi1=%h pend=%b want 00ff 1", rphi1_pat, pending);
    end
    @(negedge CLK_SYS);
    frame_sync = 1'b1;
    idle(4);
    n_vec++;
    if (rphi1_pat !== 16'h0F0F || cfg_update !== 1'b1 || pending !== 1'b0) begin
      n_err++;
      $display("FAIL collide_second got rphi1=%h upd=%b pend=%b want 0f0f 1 0", rphi1_pat, cfg_update, pending);
    end
    frame_sync = 1'b0;
    idle(4);
  endtask

  task automatic test_reset_mid;
    int upd_cnt;
    send(16'hA1A1, 16'd900, '0);
    idle(2);
    @(negedge CLK_SYS);
    RST_N = 1'b0;
    idle(2);
    RST_N = 1'b1;
    idle(1);
    n_vec++;
    if (integ_t !== 16'd1059 || pending !== 1'b0 || rphi1_pat !== 16'h80FF) begin
      n_err++;
      $display("FAIL rst_mid got integ=%0d pend=%b rphi1=%h want 1059 0 80ff", integ_t, pending, rphi1_pat);
    end
    @(negedge CLK_SYS);
    frame_sync = 1'b1;
    upd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (cfg_update) upd_cnt++;
    end
    n_vec++;
    if (upd_cnt != 0 || integ_t !== 16'd1059) begin
      n_err++;
      $display("FAIL rst_sync got updates=%0d integ=%0d want 0 1059", upd_cnt, integ_t);
    end
    frame_sync = 1'b0;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_stage_commit();
    test_errors();
    test_last_wins();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ccd_cfg_sequencer.md
Name: ccd_cfg_sequencer

Overview:
- Command decoder and frame-aligned configuration scheduler for the CCD201 timing datapath.
- Accepts 256-bit UART command frames, validates them, and stages new horizontal-clock patterns, pixel-clock pattern, integration time and OS channel select.
- Commits all staged values atomically at the next frame boundary, so the timing generator never sees a mid-frame pattern change.
- Sits between the UART receiver and the CCD timing generator.

Parameters:
- INTEG_MIN, 760: smallest legal integration time in lines; must be greater than the last active line (743).
- SYNC_TIMEOUT, 24'd8_000_000: CLK_SYS cycles a pending update may wait for frame_sync before a forced commit.

Ports:
- CLK_SYS  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- uart_ready  in  1  one-cycle strobe; UART_IN is valid while high
- UART_IN  in  256  command frame: [31:16] opcode, [15:0] value, [255:32] must be zero
- frame_sync  in  1  level from the pixel_clk domain, high while line_cnt==0; asynchronous to CLK_SYS
- rphi1_pat, rphi2_pat, rphi3_pat, phir_pat, rphi2hv_pat, pix_pat  out  16 each  active patterns
- integ_t  out  16  active integration time
- os_select  out  1  active OS channel (0=OSL, 1=OSH)
- os_rst  out  1  one-cycle pulse when os_select changes
- cfg_update  out  1  one-cycle pulse on every commit
- pending  out  1  staged changes are awaiting commit
- cmd_ack  out  1  one-cycle pulse: command accepted
- cmd_err  out  1  one-cycle pulse: command rejected
- err_code  out  2  0 none, 1 unknown opcode, 2 upper bits nonzero, 3 value illegal; held until the next command
- sync_lost  out  1  sticky; set by a timeout commit, cleared by opcode C0C1

Behaviour:

Reset:
- Active and staging values: rphi1 0x80FF, rphi2 0xF800, rphi3 0x0F80, phir 0x2000, rphi2hv 0xF003, pix 0x00F0, integ_t 1059, os_select 0.
- All pulses, pending, err_code, sync_lost and the synchroniser flops are 0.
- State is IDLE.
- Reset asserted mid-operation discards staged data immediately.

Decode (in the cycle uart_ready=1; response registered one cycle later):
- If UART_IN[255:32]!=0: reject with err 2.
- Opcode mapping: B1A1..B1A6 select rphi1, rphi2, rphi3, phir, rphi2hv, pix; A1A1 selects integ_t; A0A0 selects os_select (value bit 0).
- C0C0 forces an immediate commit; C0C1 clears sync_lost. Both are acked and stage nothing.
- Any other opcode: reject with err 1.
- Value checks, reject with err 3:
  - pix value equal to 0x0000 or 0xFFFF (no pixel-clock edges);
  - A1A1 value below INTEG_MIN;
  - A0A0 value above 1.
- Accepted write: updates the staging register, sets the field's bit in an 8-bit pending mask, pulses cmd_ack, sets err_code=0.
- A rejected command leaves all staging unchanged.

Frame sync:
- frame_sync passes through a 2-FF synchroniser, then a third flop for rising-edge detection.
- A commit triggered by the edge updates the active outputs on the 3rd CLK_SYS edge after the first edge that samples frame_sync=1.

FSM:
- IDLE: pending mask is zero. An accepted write moves to ARMED and clears the timeout counter.
- ARMED: counter increments each cycle. Go to COMMIT on a sync edge, on C0C0, or when the counter reaches SYNC_TIMEOUT-1 (timeout also sets sync_lost).
- COMMIT, one cycle:
  - Active registers take the staging values.
  - The pending mask clears.
  - cfg_update pulses together with the active-value change.
  - os_rst pulses in the same cycle if os_select changed.
  - Next state is IDLE.
- C0C0 received in IDLE: cfg_update still pulses once and values are unchanged.

Boundary cases:
- Write in the same cycle as COMMIT: the commit uses staging as it stood before that cycle. The new value lands in staging and its pending bit remains set. The FSM returns to ARMED, not IDLE.
- Repeated writes to one field before a commit: last value wins.
- A sync edge while IDLE is ignored.
- frame_sync held high for many cycles produces only one edge.
- pending = (mask != 0), registered.
- The timeout counter is 24-bit and saturates; it does not wrap.

Test Plan:
- Reset, then read all outputs -> rphi1_pat=0x80FF, pix_pat=0x00F0, integ_t=1059, os_select=0; pending, cfg_update and err_code are 0.
- UART_IN={224'd0,16'hB1A2,16'hF000} with uart_ready -> cmd_ack one cycle later, pending=1, rphi2_pat still 0xF800. Then raise frame_sync -> rphi2_pat=0xF000 and cfg_update pulse on the 3rd edge; pending=0.
- Invalid commands, each -> no staging change:
  - opcode 0xB1A7 -> cmd_err, err_code=1;
  - UART_IN[40]=1 -> err_code=2;
  - B1A6 value 0xFFFF -> err_code=3;
  - A1A1 value 700 -> err_code=3.
- Stage A0A0 value 1 and hold frame_sync=0 for SYNC_TIMEOUT cycles (sim override 100) -> commit at cycle 100, os_select=1, os_rst single pulse, sync_lost=1. C0C1 -> sync_lost=0.
- Stage B1A1=0x00FF. Apply a sync edge such that the COMMIT cycle coincides with a B1A1=0x0F0F write -> rphi1_pat=0x00FF, pending stays 1, state ARMED. The next sync edge gives rphi1_pat=0x0F0F.
- Stage A1A1=900, assert RST_N low mid-ARMED -> integ_t=1059 and pending=0 after release. A subsequent sync edge gives no cfg_update.
